// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - MIPS opcode/func constants, field positions and decode record shared by ID and ALU.
package mips_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 32;
  localparam int OP_W   = 6;
  localparam int FN_W   = 6;

  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int FN_LSB = 0;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'b001011;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  localparam logic [FN_W-1:0] FN_SLL = 6'b000000;
  localparam logic [FN_W-1:0] FN_SRL = 6'b000010;
  localparam logic [FN_W-1:0] FN_SRA = 6'b000011;
  localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FN_W-1:0] FN_SUB = 6'b100010;

  typedef struct packed {
    logic              rs_used;
    logic              rt_used;
    logic              rd_valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
  } dec_t;

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - 32x32 register file, two read ports, one write port with same-cycle bypass.
module regfile
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [XLEN-1:0]   rdata_a,
  output logic [XLEN-1:0]   rdata_b
);

  logic [XLEN-1:0] rf [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (we && waddr != '0) begin
      rf[waddr] <= wdata;
    end
  end

  // r0 is hardwired, so it wins over the bypass even when written this cycle
  always_comb begin
    rdata_a = rf[raddr_a];
    if (raddr_a == '0)                 rdata_a = '0;
    else if (we && waddr == raddr_a)   rdata_a = wdata;
    rdata_b = rf[raddr_b];
    if (raddr_b == '0)                 rdata_b = '0;
    else if (we && waddr == raddr_b)   rdata_b = wdata;
  end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - MIPS decode/issue stage: operand fetch, scoreboard interlock, EX output register.
module id_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [XLEN-1:0]   if_instr,
  output logic              if_ready,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_regA,
  output logic [XLEN-1:0]   ex_regB,
  output logic [XLEN-1:0]   ex_instr,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data
);

  logic [OP_W-1:0]  op;
  logic [FN_W-1:0]  fn;
  dec_t             dec;
  logic [NREGS-1:0] pending, clr_mask, set_mask, busy;
  logic [XLEN-1:0]  rdata_a, rdata_b;
  logic             hazard, accept;

  assign op = if_instr[OP_LSB +: OP_W];
  assign fn = if_instr[FN_LSB +: FN_W];

  always_comb begin
    dec          = '0;
    dec.rs       = if_instr[RS_LSB +: REG_AW];
    dec.rt       = if_instr[RT_LSB +: REG_AW];
    dec.rs_used  = !(op == OP_RTYPE && (fn == FN_SLL || fn == FN_SRL || fn == FN_SRA));
    dec.rt_used  = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    case (op)
      OP_RTYPE: begin
        dec.rd       = if_instr[RD_LSB +: REG_AW];
        dec.rd_valid = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW: begin
        dec.rd       = if_instr[RT_LSB +: REG_AW];
        dec.rd_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // A register being written back this cycle is no longer a hazard: the bypass supplies it
  always_comb begin
    clr_mask = '0;
    if (wb_en) clr_mask[wb_addr] = 1'b1;
    set_mask = '0;
    if (accept && dec.rd_valid && dec.rd != '0) set_mask[dec.rd] = 1'b1;
  end

  assign busy     = pending & ~clr_mask;
  assign hazard   = (dec.rs_used  && busy[dec.rs]) ||
                    (dec.rt_used  && busy[dec.rt]) ||
                    (dec.rd_valid && busy[dec.rd]);
  assign if_ready = rst_n && (!ex_valid || ex_ready) && !hazard;
  assign accept   = if_valid && if_ready;

  // Set is OR'ed after clear so a coinciding issue keeps the bit owned by the new writer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~clr_mask) | set_mask;
  end

  regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (dec.rs),
    .raddr_b (dec.rt),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_regA  <= '0;
      ex_regB  <= '0;
      ex_instr <= '0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      ex_regA  <= dec.rs_used ? rdata_a : '0;
      ex_regB  <= dec.rt_used ? rdata_b : '0;
      ex_instr <= if_instr;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - Vector table plus scoreboard bench for id_stage.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_regA, ex_regB, ex_instr;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  id_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_valid (if_valid),
    .if_instr (if_instr),
    .if_ready (if_ready),
    .ex_valid (ex_valid),
    .ex_ready (ex_ready),
    .ex_regA  (ex_regA),
    .ex_regB  (ex_regB),
    .ex_instr (ex_instr),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data)
  );

  typedef struct {
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        if_valid;
    logic [31:0] instr;
    logic        exp_rdy;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] instr;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sbq[$];
  logic [31:0] mreg [32];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic v, input logic [31:0] ins, input logic rdy);
    vec_t r;
    r.wb_en = we; r.wb_addr = wa; r.wb_data = wd;
    r.if_valid = v; r.instr = ins; r.exp_rdy = rdy;
    return r;
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wb_en && wb_addr == a) return wb_data;
    return mreg[a];
  endfunction

  function automatic logic uses_rs(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op != 6'h00) return 1'b1;
    return !(fn == 6'h00 || fn == 6'h02 || fn == 6'h03);
  endfunction

  function automatic logic uses_rt(input logic [31:0] ins);
    case (ins[31:26])
      6'h00, 6'h04, 6'h05, 6'h2B: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

  // Scoreboard: predict operands when an accept is seen, compare after the following edge
  initial begin : mon
    logic acc;
    exp_t e;
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    forever begin
      @(negedge clk); #3;
      acc = rst_n && if_valid && if_ready;
      if (acc) begin
        e.a     = uses_rs(if_instr) ? mread(if_instr[25:21]) : 32'h0;
        e.b     = uses_rt(if_instr) ? mread(if_instr[20:16]) : 32'h0;
        e.instr = if_instr;
        sbq.push_back(e);
      end
      @(posedge clk); #1;
      if (!rst_n) begin
        for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
        sbq.delete();
      end else begin
        if (wb_en && wb_addr != 5'd0) mreg[wb_addr] = wb_data;
        if (acc) begin
          e = sbq.pop_front();
          check("issue ex_valid", {31'h0, ex_valid}, 32'h1);
          check("issue ex_regA", ex_regA, e.a);
          check("issue ex_regB", ex_regB, e.b);
          check("issue ex_instr", ex_instr, e.instr);
        end
      end
    end
  end

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic v, input logic [31:0] ins, input logic er);
    wb_en = we; wb_addr = wa; wb_data = wd;
    if_valid = v; if_instr = ins; ex_ready = er;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1);
    repeat (2) @(negedge clk);
    #2;
    check("reset ex_valid", {31'h0, ex_valid}, 32'h0);
    check("reset ex_regA", ex_regA, 32'h0);
    check("reset ex_instr", ex_instr, 32'h0);
    check("reset if_ready", {31'h0, if_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back(mk(1, 5'd1,  32'd5,        0, 32'h0000_0000, 1)); // wb r1=5
    vecs.push_back(mk(1, 5'd2,  32'd7,        0, 32'h0000_0000, 1)); // wb r2=7
    vecs.push_back(mk(0, 5'd0,  32'd0,        1, 32'h0022_1820, 1)); // add r3,r1,r2
    vecs.push_back(mk(0, 5'd0,  32'd0,        1, 32'h0061_2022, 0)); // sub r4,r3,r1 stalls
    vecs.push_back(mk(0, 5'd0,  32'd0,        1, 32'h0061_2022, 0));
    vecs.push_back(mk(1, 5'd3,  32'd12,       1, 32'h0061_2022, 1)); // wb r3 releases, bypass
    vecs.push_back(mk(0, 5'd0,  32'd0,        1, 32'h2000_0009, 1)); // addi r0,r0,9
    vecs.push_back(mk(0, 5'd0,  32'd0,        1, 32'h0000_4020, 1)); // add r8,r0,r0
    vecs.push_back(mk(1, 5'd0,  32'hFFFF_FFFF,1, 32'h0000_4820, 1)); // wb r0, add r9,r0,r0
    vecs.push_back(mk(1, 5'd6,  32'h11,       1, 32'h8C07_0000, 1)); // lw r7,0(r0)
    vecs.push_back(mk(0, 5'd0,  32'd0,        1, 32'h00E6_2880, 1)); // sll r5,r6,2 rs=7
    vecs.push_back(mk(0, 5'd0,  32'd0,        1, 32'h2005_0001, 0)); // addi r5 WAW
    vecs.push_back(mk(1, 5'd5,  32'h33,       1, 32'h2005_0001, 1)); // clear+set coincide
    vecs.push_back(mk(0, 5'd0,  32'd0,        1, 32'h00A0_5020, 0)); // r5 still pending
    vecs.push_back(mk(0, 5'd0,  32'd0,        0, 32'h00A0_5020, 0));
    vecs.push_back(mk(1, 5'd5,  32'h44,       1, 32'h00A0_5020, 1)); // add r10,r5,r0
    vecs.push_back(mk(0, 5'd0,  32'd0,        0, 32'h200B_0003, 1)); // not valid: ignored
    vecs.push_back(mk(0, 5'd0,  32'd0,        1, 32'h0160_6020, 1)); // r11 must be free
    vecs.push_back(mk(0, 5'd0,  32'd0,        1, 32'h1022_0003, 1)); // beq r1,r2
    vecs.push_back(mk(0, 5'd0,  32'd0,        1, 32'hAC22_0004, 1)); // sw r2,4(r1)
    vecs.push_back(mk(0, 5'd0,  32'd0,        1, 32'h0800_0010, 1)); // j (no dest)
    vecs.push_back(mk(0, 5'd0,  32'd0,        1, 32'hAC28_0000, 0)); // sw r8 pending
    vecs.push_back(mk(1, 5'd8,  32'h99,       1, 32'hAC28_0000, 1)); // bypassed store data
    vecs.push_back(mk(0, 5'd0,  32'd0,        0, 32'h0000_0000, 1));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].wb_en, vecs[i].wb_addr, vecs[i].wb_data, vecs[i].if_valid, vecs[i].instr, 1'b1);
      #2;
      check($sformatf("if_ready row %0d", i), {31'h0, if_ready}, {31'h0, vecs[i].exp_rdy});
    end

    // Backpressure: held output, no accept until ex_ready returns
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 32'h0022_6820, 1'b1);
    #2 check("bp accept", {31'h0, if_ready}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 1'b1, 32'h1022_0003, 1'b0);
      #2;
      check("bp if_ready", {31'h0, if_ready}, 32'h0);
      check("bp ex_valid", {31'h0, ex_valid}, 32'h1);
      check("bp ex_instr", ex_instr, 32'h0022_6820);
      check("bp ex_regA", ex_regA, 32'd5);
      check("bp ex_regB", ex_regB, 32'd7);
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 32'h1022_0003, 1'b1);
    #2 check("bp release", {31'h0, if_ready}, 32'h1);

    // Reset with an instruction in flight
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 32'h0022_7820, 1'b1);
    #2 check("pre-reset accept", {31'h0, if_ready}, 32'h1);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid reset ex_valid", {31'h0, ex_valid}, 32'h0);
    check("mid reset ex_regA", ex_regA, 32'h0);
    check("mid reset ex_regB", ex_regB, 32'h0);
    check("mid reset ex_instr", ex_instr, 32'h0);
    check("mid reset if_ready", {31'h0, if_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 32'h01A1_7020, 1'b1);
    #2 check("post reset no stall", {31'h0, if_ready}, 32'h1);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1);
    repeat (2) @(negedge clk);
    check("scoreboard drained", sbq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
